obi_wb_bridge: RTL and testbench

//  Parametrised bridge from one core-side OBI port (req/gnt/rvalid) to one Wishbone classic master port.

---
 rtl/obi_wb_bridge_if.sv | 39 +++
 rtl/obi_wb_bridge.sv | 133 +++++++++++++
 tb/tb_obi_wb_bridge.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/obi_wb_bridge_if.sv
// Signal bundle between an OBI core port, the bridge and a Wishbone classic slave.
// The bridge uses the master modport because it masters Wishbone and answers OBI. The core and slave side uses slave.
interface obi_wb_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int SEL_WIDTH = DATA_WIDTH / 8;

  logic                  obi_req_i;
  logic                  obi_gnt_o;
  logic [ADDR_WIDTH-1:0] obi_addr_i;
  logic                  obi_we_i;
  logic [SEL_WIDTH-1:0]  obi_be_i;
  logic [DATA_WIDTH-1:0] obi_wdata_i;
  logic                  obi_rvalid_o;
  logic [DATA_WIDTH-1:0] obi_rdata_o;
  logic                  obi_err_o;
  logic                  wb_cyc_o;
  logic                  wb_stb_o;
  logic                  wb_we_o;
  logic [SEL_WIDTH-1:0]  wb_sel_o;
  logic [ADDR_WIDTH-1:0] wb_adr_o;
  logic [DATA_WIDTH-1:0] wb_dat_o;
  logic [DATA_WIDTH-1:0] wb_dat_i;
  logic                  wb_ack_i;
  logic                  wb_err_i;

  modport master (
    input  obi_req_i, obi_addr_i, obi_we_i, obi_be_i, obi_wdata_i, wb_dat_i, wb_ack_i, wb_err_i,
    output obi_gnt_o, obi_rvalid_o, obi_rdata_o, obi_err_o,
           wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o
  );

  modport slave (
    output obi_req_i, obi_addr_i, obi_we_i, obi_be_i, obi_wdata_i, wb_dat_i, wb_ack_i, wb_err_i,
    input  obi_gnt_o, obi_rvalid_o, obi_rdata_o, obi_err_o,
           wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o
  );
endinterface

// File: rtl/obi_wb_bridge.sv
// OBI (req/gnt/rvalid) to Wishbone classic bridge. It allows a single outstanding transfer.
// It provides a bus timeout, an optional registered response, and transfer and error counters.
module obi_wb_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int REG_RSP        = 1,
  parameter int WB_WORD_ADDR   = 0,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  obi_wb_bridge_if.master      bus,
  output logic                 timeout_o,
  output logic [CNT_WIDTH-1:0] txn_cnt_o,
  output logic [CNT_WIDTH-1:0] err_cnt_o
);
  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int ADR_SHIFT = (WB_WORD_ADDR != 0) ? $clog2(SEL_WIDTH) : 0;
  localparam int TO_WIDTH  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUS = 1'b1} state_t;

  state_t                state_r, state_s;
  logic                  we_r;
  logic [SEL_WIDTH-1:0]  sel_r;
  logic [ADDR_WIDTH-1:0] adr_r;
  logic [DATA_WIDTH-1:0] dat_r;
  logic [TO_WIDTH-1:0]   to_cnt_r;
  logic                  rvalid_r, err_r, timeout_r;
  logic [DATA_WIDTH-1:0] rdata_r;
  logic [CNT_WIDTH-1:0]  txn_cnt_r, err_cnt_r;
  logic                  gnt_s, ack_s, err_s, to_hit_s, done_s, rsp_err_s;
  logic [DATA_WIDTH-1:0] rsp_data_s;

  // A registered response still waiting to go out blocks the next grant.
  assign gnt_s = (state_r == ST_IDLE) && !((REG_RSP != 0) && rvalid_r) && bus.obi_req_i && !rst;

  // Terminating event decode: an err with an ack counts as err, and either one beats the timeout.
  always_comb begin
    ack_s    = 1'b0;
    err_s    = 1'b0;
    to_hit_s = 1'b0;
    if (state_r == ST_BUS) begin
      ack_s    = bus.wb_ack_i && !bus.wb_err_i;
      err_s    = bus.wb_err_i;
      to_hit_s = (TIMEOUT_CYCLES != 0) && !bus.wb_ack_i && !bus.wb_err_i && (to_cnt_r == TO_LAST);
    end else begin
      ack_s    = 1'b0;
    end
  end

  assign done_s     = ack_s || err_s || to_hit_s;
  assign rsp_err_s  = err_s || to_hit_s;
  assign rsp_data_s = (ack_s && !we_r) ? bus.wb_dat_i : {DATA_WIDTH{1'b0}};

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: if (gnt_s) state_s = ST_BUS;  else state_s = ST_IDLE;
      ST_BUS:  if (done_s) state_s = ST_IDLE; else state_s = ST_BUS;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_s;
  end

  // Wishbone request registers: loaded on grant, cleared when the transfer ends
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_r  <= 1'b0;
      sel_r <= {SEL_WIDTH{1'b0}};
      adr_r <= {ADDR_WIDTH{1'b0}};
      dat_r <= {DATA_WIDTH{1'b0}};
    end else if (gnt_s) begin
      we_r  <= bus.obi_we_i;
      sel_r <= bus.obi_be_i;
      adr_r <= bus.obi_addr_i >> ADR_SHIFT;
      dat_r <= bus.obi_wdata_i;
    end else if (done_s) begin
      we_r  <= 1'b0;
      sel_r <= {SEL_WIDTH{1'b0}};
      adr_r <= {ADDR_WIDTH{1'b0}};
      dat_r <= {DATA_WIDTH{1'b0}};
    end
  end

  // Cycles spent in BUS, measured from 0 on the first BUS cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               to_cnt_r <= {TO_WIDTH{1'b0}};
    else if (state_r == ST_BUS && !done_s) to_cnt_r <= to_cnt_r + TO_WIDTH'(1'b1);
    else                                   to_cnt_r <= {TO_WIDTH{1'b0}};
  end

  // Response register and status counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_r  <= 1'b0;
      err_r     <= 1'b0;
      timeout_r <= 1'b0;
      rdata_r   <= {DATA_WIDTH{1'b0}};
      txn_cnt_r <= {CNT_WIDTH{1'b0}};
      err_cnt_r <= {CNT_WIDTH{1'b0}};
    end else begin
      rvalid_r  <= done_s;
      err_r     <= rsp_err_s;
      timeout_r <= to_hit_s;
      rdata_r   <= rsp_data_s;
      if (done_s)    txn_cnt_r <= txn_cnt_r + CNT_WIDTH'(1'b1);
      if (rsp_err_s) err_cnt_r <= err_cnt_r + CNT_WIDTH'(1'b1);
    end
  end

  assign bus.obi_gnt_o    = gnt_s;
  assign bus.obi_rvalid_o = (REG_RSP != 0) ? rvalid_r : done_s;
  assign bus.obi_rdata_o  = (REG_RSP != 0) ? rdata_r : rsp_data_s;
  assign bus.obi_err_o    = (REG_RSP != 0) ? err_r : rsp_err_s;
  assign timeout_o        = (REG_RSP != 0) ? timeout_r : to_hit_s;
  assign bus.wb_cyc_o     = (state_r == ST_BUS);
  assign bus.wb_stb_o     = (state_r == ST_BUS);
  assign bus.wb_we_o      = we_r;
  assign bus.wb_sel_o     = sel_r;
  assign bus.wb_adr_o     = adr_r;
  assign bus.wb_dat_o     = dat_r;
  assign txn_cnt_o        = txn_cnt_r;
  assign err_cnt_o        = err_cnt_r;
endmodule

// File: tb/tb_obi_wb_bridge.sv
// Bench for obi_wb_bridge. Instance A uses a registered response, word addressing and an 8-cycle timeout.
// Instance B uses a combinational response and byte addressing.
module tb_obi_wb_bridge;
  localparam int TO_A = 8;
  localparam int TO_B = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  obi_wb_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_a ();
  obi_wb_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_b ();
  logic        timeout_a, timeout_b;
  logic [15:0] txn_a, errc_a, txn_b, errc_b;

  obi_wb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .REG_RSP(1), .WB_WORD_ADDR(1),
                  .TIMEOUT_CYCLES(TO_A), .CNT_WIDTH(16))
    u_dut_a (.clk(clk), .rst(rst), .bus(bus_a), .timeout_o(timeout_a), .txn_cnt_o(txn_a), .err_cnt_o(errc_a));

  obi_wb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .REG_RSP(0), .WB_WORD_ADDR(0),
                  .TIMEOUT_CYCLES(TO_B), .CNT_WIDTH(16))
    u_dut_b (.clk(clk), .rst(rst), .bus(bus_b), .timeout_o(timeout_b), .txn_cnt_o(txn_b), .err_cnt_o(errc_b));

  int checks = 0;
  int errors = 0;
  int exp_txn = 0;
  int exp_errc = 0;

  task automatic check_value(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  // One transfer on A. The slave answers after 'delay' BUS cycles: kind 0 = ack, 1 = err, 2 = ack+err.
  // A delay of TO_A or more means the slave does not answer inside the transfer, so the answer arrives later while idle.
  task automatic run_a(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, input logic [31:0] rd, input int delay, input int kind);
    int exp_bus, rv_cnt, to_cnt, cyc_cnt;
    logic exp_to, exp_err;
    logic [31:0] exp_rd;
    exp_to  = (delay >= TO_A);
    exp_err = exp_to || (kind != 0);
    exp_rd  = (exp_err || we) ? 32'h0 : rd;
    exp_bus = exp_to ? TO_A : delay + 1;
    rv_cnt = 0; to_cnt = 0; cyc_cnt = 0;
    @(negedge clk);
    bus_a.obi_req_i = 1'b1; bus_a.obi_we_i = we; bus_a.obi_addr_i = addr;
    bus_a.obi_be_i = be; bus_a.obi_wdata_i = wd;
    #1 check_value("a_gnt", bus_a.obi_gnt_o, 1'b1);
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      bus_a.obi_req_i = (k == exp_bus);
      bus_a.wb_ack_i  = (k == delay) && (kind != 1);
      bus_a.wb_err_i  = (k == delay) && (kind != 0);
      bus_a.wb_dat_i  = (k == delay) ? rd : $urandom;
      if (k == 0) begin
        check_value("a_cyc_stb", {bus_a.wb_cyc_o, bus_a.wb_stb_o}, 2'b11);
        check_value("a_adr", bus_a.wb_adr_o, addr >> 2);
        check_value("a_sel", bus_a.wb_sel_o, be);
        check_value("a_we", bus_a.wb_we_o, we);
        check_value("a_dat", bus_a.wb_dat_o, wd);
      end
      if (k == exp_bus)
        check_value("a_wb_idle", {bus_a.wb_we_o, bus_a.wb_sel_o, bus_a.wb_adr_o, bus_a.wb_dat_o}, 64'h0);
      if (bus_a.wb_cyc_o) cyc_cnt++;
      if (timeout_a) begin
        to_cnt++;
        check_value("a_to_cycle", k, exp_bus);
      end
      if (bus_a.obi_rvalid_o) begin
        rv_cnt++;
        exp_txn  = (exp_txn + 1) & 16'hFFFF;
        exp_errc = (exp_errc + (exp_err ? 1 : 0)) & 16'hFFFF;
        check_value("a_rv_cycle", k, exp_bus);
        check_value("a_rdata", bus_a.obi_rdata_o, exp_rd);
        check_value("a_err", bus_a.obi_err_o, exp_err);
        check_value("a_txn_cnt", txn_a, exp_txn);
        check_value("a_err_cnt", errc_a, exp_errc);
      end
      if (k == exp_bus) #1 check_value("a_gnt_blocked", bus_a.obi_gnt_o, 1'b0);
    end
    bus_a.obi_req_i = 1'b0; bus_a.wb_ack_i = 1'b0; bus_a.wb_err_i = 1'b0;
    check_value("a_cyc_len", cyc_cnt, exp_bus);
    check_value("a_rv_count", rv_cnt, 1);
    check_value("a_to_count", to_cnt, exp_to ? 1 : 0);
  endtask

  int rv_seen;
  int d;
  logic [31:0] rd_v, ad_v;
  logic [31:0] exp_q[$];

  initial begin
    rst = 1'b1;
    bus_a.obi_req_i = 1'b1; bus_a.obi_addr_i = 32'h0; bus_a.obi_we_i = 1'b0; bus_a.obi_be_i = 4'h0;
    bus_a.obi_wdata_i = 32'h0; bus_a.wb_dat_i = 32'h0; bus_a.wb_ack_i = 1'b0; bus_a.wb_err_i = 1'b0;
    bus_b.obi_req_i = 1'b1; bus_b.obi_addr_i = 32'h0; bus_b.obi_we_i = 1'b0; bus_b.obi_be_i = 4'h0;
    bus_b.obi_wdata_i = 32'h0; bus_b.wb_dat_i = 32'h0; bus_b.wb_ack_i = 1'b0; bus_b.wb_err_i = 1'b0;
    #12;
    check_value("rst_gnt", {bus_a.obi_gnt_o, bus_b.obi_gnt_o}, 2'b00);
    check_value("rst_rvalid", {bus_a.obi_rvalid_o, bus_a.obi_err_o, bus_a.obi_rdata_o}, 34'h0);
    check_value("rst_wb", {bus_a.wb_cyc_o, bus_a.wb_stb_o, bus_a.wb_we_o, bus_a.wb_sel_o, bus_a.wb_adr_o}, 39'h0);
    check_value("rst_status", {timeout_a, txn_a, errc_a}, 33'h0);
    bus_a.obi_req_i = 1'b0; bus_b.obi_req_i = 1'b0;
    @(negedge clk) rst = 1'b0;

    run_a(1'b0, 32'h0000_0100, 4'hF, 32'h0, 32'hDEAD_BEEF, 0, 0);
    run_a(1'b1, 32'h0000_1004, 4'b0011, 32'h1234_5678, 32'hCAFE_F00D, 0, 0);
    run_a(1'b0, 32'h0000_2000, 4'hF, 32'h0, 32'h1111_2222, 20, 0);
    run_a(1'b0, 32'h0000_3008, 4'hF, 32'h0, 32'h3333_4444, 2, 2);
    run_a(1'b0, 32'h0000_4000, 4'hF, 32'h0, 32'h5555_6666, 7, 0);
    run_a(1'b1, 32'h0000_5000, 4'hC, 32'hABCD_0000, 32'h0, 7, 1);

    // Reset in the middle of a transfer the slave never answers
    @(negedge clk);
    bus_a.obi_req_i = 1'b1; bus_a.obi_we_i = 1'b0; bus_a.obi_addr_i = 32'h0000_6000; bus_a.obi_be_i = 4'hF;
    #1 check_value("r_gnt", bus_a.obi_gnt_o, 1'b1);
    @(negedge clk) bus_a.obi_req_i = 1'b0;
    repeat (2) @(negedge clk);
    check_value("r_cyc_before", bus_a.wb_cyc_o, 1'b1);
    #1 rst = 1'b1;
    #1 check_value("r_cyc_async", {bus_a.wb_cyc_o, bus_a.wb_sel_o, bus_a.wb_adr_o}, 37'h0);
    @(negedge clk) rst = 1'b0;
    exp_txn = 0; exp_errc = 0; rv_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus_a.obi_rvalid_o || bus_a.wb_cyc_o) rv_seen++;
    end
    check_value("r_no_rvalid", rv_seen, 0);
    check_value("r_counters", {txn_a, errc_a}, 32'h0);
    run_a(1'b0, 32'h0000_7004, 4'hF, 32'h0, 32'h7777_8888, 1, 0);

    for (int i = 0; i < 30; i++)
      run_a(1'($urandom_range(1, 0)), $urandom, 4'($urandom_range(15, 1)), $urandom, $urandom,
            $urandom_range(12, 0), $urandom_range(2, 0));

    // B: 100 back-to-back reads with ack delay 0..5, response in the ack cycle itself
    rv_seen = 0;
    bus_b.obi_we_i = 1'b0; bus_b.obi_be_i = 4'hF;
    for (int i = 0; i < 100; i++) begin
      d = $urandom_range(5, 0); rd_v = $urandom; ad_v = $urandom;
      @(negedge clk);
      bus_b.wb_ack_i = 1'b0; bus_b.obi_req_i = 1'b1; bus_b.obi_addr_i = ad_v;
      #1 check_value("b_gnt", bus_b.obi_gnt_o, 1'b1);
      exp_q.push_back(rd_v);
      for (int k = 0; k <= d; k++) begin
        @(negedge clk);
        bus_b.wb_ack_i = (k == d);
        bus_b.wb_dat_i = (k == d) ? rd_v : $urandom;
        #1;
        if (k == 0) check_value("b_adr", bus_b.wb_adr_o, ad_v);
        check_value("b_gnt_bus", bus_b.obi_gnt_o, 1'b0);
        check_value("b_rv_in_ack", bus_b.obi_rvalid_o, (k == d));
        if (bus_b.obi_rvalid_o) begin
          rv_seen++;
          if (exp_q.size() > 0) check_value("b_rdata", bus_b.obi_rdata_o, exp_q.pop_front());
          else check_value("b_rdata_unexpected", bus_b.obi_rdata_o, 32'h0);
          check_value("b_err", bus_b.obi_err_o, 1'b0);
        end
      end
    end
    @(negedge clk);
    bus_b.wb_ack_i = 1'b0; bus_b.obi_req_i = 1'b0;
    #1;
    check_value("b_rv_total", rv_seen, 100);
    check_value("b_txn_cnt", txn_b, 16'd100);
    check_value("b_err_cnt", errc_b, 16'd0);
    check_value("b_timeout", timeout_b, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
